// File: rtl/eig_result_monitor.sv
// Result monitor for the eigen-analysis core: registers each result, grades it,
// counts consecutive bad samples into a sticky alarm and flags stale output.
module eig_result_monitor #(
   parameter int W = 32,
   parameter int STRIKES = 4,
   parameter int TIMEOUT = 1024,
   parameter logic signed [W-1:0] KAPPA_MAX = 32'sh0010_0000,
   parameter int CNT_W = 16,
   localparam int SW = $clog2(STRIKES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                res_valid,
   input  logic signed [W-1:0] kappa,
   input  logic signed [W-1:0] inv_kappa,
   input  logic [2:0]          regime,
   input  logic                alarm_clr,
   output logic                out_valid,
   output logic [W-1:0]        kappa_q,
   output logic [W-1:0]        inv_kappa_q,
   output logic [2:0]          regime_q,
   output logic [SW-1:0]       strike_cnt,
   output logic                alarm,
   output logic                stale,
   output logic                regime_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MONITOR = 2'd1,
      ALARM   = 2'd2
   } state_t;

   localparam logic [SW-1:0]    SMAX = SW'(STRIKES);
   localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

   state_t           state, state_d;
   logic [SW-1:0]    strike_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             stale_d;
   logic             rerr_d;
   logic             ov_d;
   logic             load;

   logic             one_hot;
   logic             bad;
   logic [W:0]       kx;
   logic [W:0]       abs_k;

   // Magnitude in W+1 bits so the most-negative kappa stays positive
   assign kx      = {kappa[W-1], kappa};
   assign abs_k   = kx[W] ? (~kx + 1'b1) : kx;
   assign one_hot = (regime == 3'b001) || (regime == 3'b010) ||
                    (regime == 3'b100);
   assign bad     = (regime == 3'b100) || !one_hot ||
                    (abs_k > {1'b0, KAPPA_MAX});

   assign alarm = (state == ALARM);

   always_comb begin
      state_d  = state;
      strike_d = strike_cnt;
      cnt_d    = cnt;
      stale_d  = stale;
      rerr_d   = regime_err;
      ov_d     = 1'b0;
      load     = 1'b0;
      if (alarm_clr) begin
         state_d  = IDLE;
         strike_d = '0;
         cnt_d    = '0;
         stale_d  = 1'b0;
         rerr_d   = 1'b0;
      end else begin
         if (res_valid) begin
            load = 1'b1;
            ov_d = 1'b1;
            if (bad)
               strike_d = (strike_cnt == SMAX) ? SMAX : strike_cnt + 1'b1;
            else if (state != ALARM)
               strike_d = '0;
            if (!one_hot)
               rerr_d = 1'b1;
         end
         case (state)
            IDLE: begin
               cnt_d   = '0;
               stale_d = 1'b0;
               if (res_valid)
                  state_d = (strike_d == SMAX) ? ALARM : MONITOR;
            end
            MONITOR: begin
               if (res_valid && strike_d == SMAX)
                  state_d = ALARM;
            end
            ALARM: state_d = ALARM;
            default: state_d = IDLE;
         endcase
         if (state != IDLE) begin
            if (res_valid)
               cnt_d = '0;
            else if (cnt != TMAX)
               cnt_d = cnt + 1'b1;
            stale_d = (cnt_d == TMAX);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         strike_cnt  <= '0;
         cnt         <= '0;
         stale       <= 1'b0;
         regime_err  <= 1'b0;
         out_valid   <= 1'b0;
         kappa_q     <= '0;
         inv_kappa_q <= '0;
         regime_q    <= '0;
      end else begin
         state      <= state_d;
         strike_cnt <= strike_d;
         cnt        <= cnt_d;
         stale      <= stale_d;
         regime_err <= rerr_d;
         out_valid  <= ov_d;
         if (load) begin
            kappa_q     <= kappa;
            inv_kappa_q <= inv_kappa;
            regime_q    <= regime;
         end
      end
   end

endmodule

// File: tb/tb_eig_result_monitor.sv
// Bench for eig_result_monitor: scoreboarded samples checked on out_valid,
// plus directed checks for alarm, clear, timeout and reset behaviour.
module tb_eig_result_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic [31:0] kappa;
   logic [31:0] inv_kappa;
   logic [2:0]  regime;
   logic        alarm_clr;
   logic        out_valid;
   logic [31:0] kappa_q;
   logic [31:0] inv_kappa_q;
   logic [2:0]  regime_q;
   logic [2:0]  strike_cnt;
   logic        alarm;
   logic        stale;
   logic        regime_err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] k;
      logic [31:0] ik;
      logic [2:0]  r;
      int          strike;
      logic        alm;
      logic        rerr;
   } exp_t;

   exp_t sb[$];

   int   m_state;
   int   m_strike;
   logic m_rerr;

   eig_result_monitor dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .kappa(kappa),
      .inv_kappa(inv_kappa), .regime(regime), .alarm_clr(alarm_clr),
      .out_valid(out_valid), .kappa_q(kappa_q), .inv_kappa_q(inv_kappa_q),
      .regime_q(regime_q), .strike_cnt(strike_cnt), .alarm(alarm),
      .stale(stale), .regime_err(regime_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every out_valid pulse must match the oldest expectation
   always @(posedge clk) begin
      #1;
      if (out_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected out_valid with empty queue");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (kappa_q !== e.k || inv_kappa_q !== e.ik ||
                regime_q !== e.r || strike_cnt !== 3'(e.strike) ||
                alarm !== e.alm || regime_err !== e.rerr) begin
               failures++;
               $display("FAIL sb_sample got k=%h ik=%h r=%b s=%0d a=%b re=%b want k=%h ik=%h r=%b s=%0d a=%b re=%b",
                        kappa_q, inv_kappa_q, regime_q, strike_cnt, alarm,
                        regime_err, e.k, e.ik, e.r, e.strike, e.alm, e.rerr);
            end
         end
      end
   end

   function automatic void model_reset();
      m_state  = 0;
      m_strike = 0;
      m_rerr   = 1'b0;
   endfunction

   task automatic send(input logic [31:0] k, input logic [31:0] ik,
                       input logic [2:0] r);
      exp_t   e;
      longint mag;
      logic   oh, bd;
      @(negedge clk);
      kappa     = k;
      inv_kappa = ik;
      regime    = r;
      res_valid = 1'b1;
      mag = longint'($signed(k));
      if (mag < 0) mag = -mag;
      oh = (r == 3'b001) || (r == 3'b010) || (r == 3'b100);
      bd = (r == 3'b100) || !oh || (mag > 64'h0010_0000);
      if (bd) m_strike = (m_strike == 4) ? 4 : m_strike + 1;
      else if (m_state != 2) m_strike = 0;
      if (!oh) m_rerr = 1'b1;
      if (m_strike == 4) m_state = 2;
      else if (m_state == 0) m_state = 1;
      e.k = k; e.ik = ik; e.r = r; e.strike = m_strike;
      e.alm = (m_state == 2); e.rerr = m_rerr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL send_out_valid got %b want 1", out_valid);
      end
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      alarm_clr = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      alarm_clr = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         res_valid = 1'($urandom);
         kappa     = $urandom;
         inv_kappa = $urandom;
         regime    = 3'($urandom);
         alarm_clr = 1'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, kappa_q, inv_kappa_q, regime_q, strike_cnt,
              alarm, stale, regime_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b k=%h ik=%h r=%b s=%0d a=%b st=%b re=%b want all 0",
                     out_valid, kappa_q, inv_kappa_q, regime_q, strike_cnt,
                     alarm, stale, regime_err);
         end
      end
      @(negedge clk);
      res_valid = 1'b0;
      alarm_clr = 1'b0;
      rst       = 1'b0;
      model_reset();
      send(32'h0001_8000, 32'h0000_AAAA, 3'b001);
   endtask

   task automatic test_strikes();
      do_clear();
      for (int i = 0; i < 4; i++)
         send(32'h0000_4000 + i, 32'h0004_0000, 3'b100);
      send(32'h0000_2000, 32'h0008_0000, 3'b001);
      checks++;
      if (alarm !== 1'b1 || strike_cnt !== 3'd4) begin
         failures++;
         $display("FAIL alarm_hold got a=%b s=%0d want a=1 s=4",
                  alarm, strike_cnt);
      end
   endtask

   task automatic test_recover();
      do_clear();
      repeat (3) send(32'h0000_1000, 32'h0010_0000, 3'b100);
      send(32'h0000_1000, 32'h0010_0000, 3'b001);
      checks++;
      if (strike_cnt !== 3'd0 || alarm !== 1'b0) begin
         failures++;
         $display("FAIL recover got s=%0d a=%b want s=0 a=0",
                  strike_cnt, alarm);
      end
      send(32'h0010_0001, 32'h0000_0FFF, 3'b001);
      send(32'h0010_0000, 32'h0000_1000, 3'b010);
      send(32'h8000_0000, 32'h0000_0000, 3'b001);
      send(32'hFFF0_0000, 32'hFFFF_F000, 3'b001);
   endtask

   task automatic test_regime_err();
      do_clear();
      send(32'h0002_0000, 32'h0000_8000, 3'b011);
      do_clear();
      checks++;
      if (alarm !== 1'b0 || regime_err !== 1'b0 || strike_cnt !== 3'd0 ||
          kappa_q !== 32'h0002_0000 || stale !== 1'b0) begin
         failures++;
         $display("FAIL clr_state got a=%b re=%b s=%0d k=%h st=%b want 0 0 0 00020000 0",
                  alarm, regime_err, strike_cnt, kappa_q, stale);
      end
   endtask

   task automatic test_timeout();
      do_clear();
      send(32'h0000_3000, 32'h0005_5555, 3'b010);
      repeat (1023) @(posedge clk);
      #1;
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("FAIL stale_early got %b want 0", stale);
      end
      @(posedge clk);
      #1;
      checks++;
      if (stale !== 1'b1) begin
         failures++;
         $display("FAIL stale_expire got %b want 1", stale);
      end
      send(32'h0000_3001, 32'h0005_5554, 3'b010);
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("FAIL stale_clear got %b want 0", stale);
      end
      repeat (1023) @(posedge clk);
      send(32'h0000_3002, 32'h0005_5553, 3'b001);
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("FAIL stale_race got %b want 0", stale);
      end
   endtask

   task automatic test_clr_collision();
      do_clear();
      repeat (4) send(32'h0000_7777, 32'h0002_2222, 3'b100);
      @(negedge clk);
      alarm_clr = 1'b1;
      res_valid = 1'b1;
      kappa     = 32'h1234_5678;
      regime    = 3'b001;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || kappa_q !== 32'h0000_7777 ||
          alarm !== 1'b0) begin
         failures++;
         $display("FAIL clr_collision got ov=%b k=%h a=%b want 0 00007777 0",
                  out_valid, kappa_q, alarm);
      end
      @(negedge clk);
      alarm_clr = 1'b0;
      res_valid = 1'b0;
      model_reset();
   endtask

   task automatic test_rst_mid();
      send(32'h0000_0100, 32'h0100_0000, 3'b001);
      repeat (500) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (stale !== 1'b0 || kappa_q !== 32'h0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid got st=%b k=%h ov=%b want 0 0 0",
                  stale, kappa_q, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (600) @(posedge clk);
      #1;
      checks++;
      if (stale !== 1'b0) begin
         failures++;
         $display("FAIL rst_counter got st=%b want 0", stale);
      end
   endtask

   initial begin
      rst = 1'b1; res_valid = 1'b0; alarm_clr = 1'b0;
      kappa = '0; inv_kappa = '0; regime = '0;
      model_reset();
      test_reset();
      test_strikes();
      test_recover();
      test_regime_err();
      test_timeout();
      test_clr_collision();
      test_rst_mid();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eig_result_monitor.md
Name: eig_result_monitor

Overview:
- Downstream consumer of the eigen-analysis core. Captures each completed result (kappa, inv_kappa, regime) and re-publishes it registered.
- Grades every sample as good or bad and counts consecutive bad samples. Raises a sticky watchdog alarm after STRIKES consecutive bad results.
- Flags a stale condition when no result arrives within TIMEOUT cycles.

Parameters:
- W, 32: data width of kappa/inv_kappa (signed 16.16 fixed point).
- STRIKES, 4: consecutive bad samples required to raise alarm (>=1).
- TIMEOUT, 1024: cycles without a result before stale asserts (>=2).
- KAPPA_MAX, 32'sh0010_0000: magnitude limit for kappa (16.0 in 16.16); |kappa| > KAPPA_MAX is bad.
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- res_valid  in  1  single-cycle strobe: kappa/inv_kappa/regime valid this cycle
- kappa  in  W  signed kappa from core
- inv_kappa  in  W  signed 1/kappa from core
- regime  in  3  one-hot regime: 001 underdamped, 010 critical, 100 overdamped
- alarm_clr  in  1  clears alarm, regime_err, counters; returns to IDLE
- out_valid  out  1  one-cycle pulse, registered outputs just updated
- kappa_q  out  W  last accepted kappa
- inv_kappa_q  out  W  last accepted inv_kappa
- regime_q  out  3  last accepted regime
- strike_cnt  out  $clog2(STRIKES+1)  current consecutive-bad count
- alarm  out  1  sticky watchdog alarm
- stale  out  1  no result for TIMEOUT cycles
- regime_err  out  1  sticky: non-one-hot regime seen

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: every output is 0; state is IDLE; timeout counter is 0. rst overrides all other inputs in the same cycle, including mid-operation.
- Acceptance:
  - A sample is accepted on the rising edge where res_valid=1 and alarm_clr=0.
  - kappa_q, inv_kappa_q and regime_q load on that edge. out_valid is 1 for exactly the following cycle (latency 1).
  - Consecutive res_valid strobes are each accepted.
- Grading:
  - A sample is bad if regime==100, or regime is not one-hot, or |kappa| > KAPPA_MAX.
  - |kappa| is computed in W+1 bits, so the most-negative kappa is handled correctly (it is bad).
  - A non-one-hot regime also sets regime_err (sticky).
  - All other samples are good.
- strike_cnt:
  - A bad sample increments it, saturating at STRIKES.
  - A good sample resets it to 0, except in ALARM, where it is held.
  - Updates on the same edge as kappa_q.
- FSM states: IDLE, MONITOR, ALARM.
  - IDLE -> MONITOR on the first accepted sample. That sample is graded normally, so STRIKES=1 with a bad first sample goes directly to ALARM.
  - MONITOR -> ALARM on the edge where the updated strike_cnt equals STRIKES. alarm=1 from that edge onward.
  - ALARM: samples are still accepted and re-published (out_valid pulses). alarm stays 1 and strike_cnt holds STRIKES.
  - Any state -> IDLE on alarm_clr=1. This clears alarm, regime_err, strike_cnt, stale and the timeout counter. kappa_q, inv_kappa_q and regime_q hold their values.
- Timeout:
  - Counter runs in MONITOR and ALARM, reset to 0 on every accepted sample, saturating at TIMEOUT.
  - stale=1 on the edge the counter reaches TIMEOUT, i.e. TIMEOUT cycles after the last accepted sample.
  - stale clears on the next accepted sample, on the same edge.
  - In IDLE the counter is 0 and stale is 0.
- Simultaneous events:
  - alarm_clr with res_valid: clear wins; the sample is dropped and out_valid stays 0.
  - res_valid on the edge the timeout would expire: sample wins, stale stays 0.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs 0; then res_valid with kappa=0x0001_8000, regime=001 -> next cycle out_valid=1, kappa_q=0x0001_8000, strike_cnt=0, alarm=0.
- 4 consecutive strobes with regime=100 -> strike_cnt 1,2,3,4; alarm=1 on the 4th acceptance edge. A following good sample keeps strike_cnt=4 and alarm=1.
- Bad sequence 100,100,100, then good 001 -> strike_cnt returns to 0 and alarm stays 0. Separately, kappa=0x0010_0001 counts as bad, kappa=0x0010_0000 is good, and kappa=0x8000_0000 is bad.
- regime=011 -> regime_err=1 and strike_cnt=1. alarm_clr=1 -> next cycle alarm=0, regime_err=0, strike_cnt=0, state IDLE, kappa_q unchanged.
- After one accepted sample, idle for 1023 cycles -> stale=0; at cycle 1024 stale=1. The next res_valid clears stale on its acceptance edge.
- alarm_clr and res_valid in the same cycle while in ALARM -> out_valid=0, kappa_q unchanged, alarm=0. Separately, assert rst mid-way through the timeout count -> stale=0 and counter=0.
